// File: rtl/stage_seq_ctrl.sv
// stage_seq_ctrl: multi-cycle IF/ID/EX/[MEM]/WB sequencer for the rvseed core; owns the architectural PC.
// Latency: one cycle per stage with zero-latency units (4 cycles/instr, 5 with MEM); every output is registered.
// Backpressure: each stage waits for its own done pulse; define STAGE_SEQ_WDT_EN to add a watchdog
// that aborts a stalled stage to IDLE and latches wdt_err.
module stage_seq_ctrl #(
  parameter int unsigned          CPU_WIDTH = 32,
  parameter logic [CPU_WIDTH-1:0] RST_PC    = '0,
  parameter int unsigned          WDT_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  output logic                 ifu_start_en,
  input  logic                 ifu_done_en,
  output logic                 idu_start_en,
  input  logic                 idu_done_en,
  output logic                 exu_start_en,
  input  logic                 exu_done_en,
  input  logic                 exu_redirect,
  input  logic [CPU_WIDTH-1:0] exu_redirect_pc,
  input  logic                 exu_mem_need,
  output logic                 meu_start_en,
  input  logic                 meu_done_en,
  output logic                 wbu_start_en,
  input  logic                 wbu_done_en,
  output logic [CPU_WIDTH-1:0] cur_pc,
  output logic                 pc_upd_en,
  output logic                 busy,
  output logic [2:0]           state,
  output logic [31:0]          inst_cnt,
  output logic                 wdt_err
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_IF   = 3'd1,
    S_ID   = 3'd2,
    S_EX   = 3'd3,
    S_MEM  = 3'd4,
    S_WB   = 3'd5
  } state_e;

  localparam logic [CPU_WIDTH-1:0] PC_STEP = CPU_WIDTH'(4);

  state_e                 state_q;
  logic                   redir_q;      // taken branch/jump captured at EX done
  logic [CPU_WIDTH-1:0]   redir_pc_q;   // its target
  logic                   mem_need_q;   // instruction routed through MEM
  logic                   stage_done;   // done of the stage we are currently in
  logic [CPU_WIDTH-1:0]   next_pc;
  logic                   wdt_trip;     // watchdog fires this cycle
  logic                   wdt_hold;     // sticky watchdog error blocks restart

  assign state = state_q;

  // Pick the done that belongs to the current stage; all other dones are ignored.
  always_comb begin
    stage_done = 1'b0;
    case (state_q)
      S_IF:    stage_done = ifu_done_en;
      S_ID:    stage_done = idu_done_en;
      S_EX:    stage_done = exu_done_en;
      S_MEM:   stage_done = meu_done_en && mem_need_q;
      S_WB:    stage_done = wbu_done_en;
      default: stage_done = 1'b0;
    endcase
  end

  // Architectural next PC: redirect target if EX reported a taken branch, else sequential.
  always_comb begin
    next_pc = cur_pc + PC_STEP;
    if (redir_q) begin
      next_pc = redir_pc_q;
    end
  end

`ifdef STAGE_SEQ_WDT_EN
  localparam logic [WDT_W-1:0] WDT_LAST = {{(WDT_W-1){1'b1}}, 1'b0};

  logic [WDT_W-1:0] wdt_cnt;
  logic             wdt_err_q;

  // Trip on the cycle the stall counter would reach its all-ones value.
  assign wdt_trip = (state_q != S_IDLE) && !stage_done && (wdt_cnt == WDT_LAST);
  assign wdt_hold = wdt_err_q;
  assign wdt_err  = wdt_err_q;

  // Stall counter: cleared in IDLE and on every stage exit, counts cycles without a done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdt_cnt <= '0;
    end else if ((state_q == S_IDLE) || stage_done) begin
      wdt_cnt <= '0;
    end else begin
      wdt_cnt <= wdt_cnt + 1'b1;
    end
  end

  // Watchdog error is sticky until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdt_err_q <= 1'b0;
    end else if (wdt_trip) begin
      wdt_err_q <= 1'b1;
    end
  end
`else
  assign wdt_trip = 1'b0;
  assign wdt_hold = 1'b0;
  assign wdt_err  = 1'b0;
`endif

  // Sequencer FSM: registered start pulses on stage entry, PC/counter update on retire.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      ifu_start_en <= 1'b0;
      idu_start_en <= 1'b0;
      exu_start_en <= 1'b0;
      meu_start_en <= 1'b0;
      wbu_start_en <= 1'b0;
      pc_upd_en    <= 1'b0;
      busy         <= 1'b0;
      cur_pc       <= RST_PC;
      inst_cnt     <= '0;
      redir_q      <= 1'b0;
      redir_pc_q   <= '0;
      mem_need_q   <= 1'b0;
    end else begin
      // Pulses are one cycle wide unless re-armed by a transition below.
      ifu_start_en <= 1'b0;
      idu_start_en <= 1'b0;
      exu_start_en <= 1'b0;
      meu_start_en <= 1'b0;
      wbu_start_en <= 1'b0;
      pc_upd_en    <= 1'b0;

      if (wdt_trip) begin
        // Abort the stalled instruction without touching PC or retire count.
        state_q    <= S_IDLE;
        busy       <= 1'b0;
        redir_q    <= 1'b0;
        mem_need_q <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (enable && !wdt_hold) begin
              state_q      <= S_IF;
              ifu_start_en <= 1'b1;
              busy         <= 1'b1;
            end
          end

          S_IF: begin
            if (stage_done) begin
              state_q      <= S_ID;
              idu_start_en <= 1'b1;
            end
          end

          S_ID: begin
            if (stage_done) begin
              state_q      <= S_EX;
              exu_start_en <= 1'b1;
            end
          end

          S_EX: begin
            if (stage_done) begin
              redir_q    <= exu_redirect;
              redir_pc_q <= exu_redirect_pc;
              mem_need_q <= exu_mem_need;
              if (exu_mem_need) begin
                state_q      <= S_MEM;
                meu_start_en <= 1'b1;
              end else begin
                state_q      <= S_WB;
                wbu_start_en <= 1'b1;
              end
            end
          end

          S_MEM: begin
            if (stage_done) begin
              state_q      <= S_WB;
              wbu_start_en <= 1'b1;
            end
          end

          S_WB: begin
            if (stage_done) begin
              // Retire: the new PC and its update strobe appear together.
              cur_pc     <= next_pc;
              pc_upd_en  <= 1'b1;
              inst_cnt   <= inst_cnt + 32'd1;
              redir_q    <= 1'b0;
              mem_need_q <= 1'b0;
              // enable is only consulted at instruction boundaries.
              if (enable) begin
                state_q      <= S_IF;
                ifu_start_en <= 1'b1;
              end else begin
                state_q <= S_IDLE;
                busy    <= 1'b0;
              end
            end
          end

          default: begin
            state_q <= S_IDLE;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
